// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: multiplier state encoding,
// default operand width and the control-FSM state that waits on the multiplier.
package mips_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_RUN  = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_e;

  // Control FSM parks here after pulsing MultStart until MultDone is seen
  localparam logic [4:0] CTRL_S_MULT_WAIT = 5'd20;

endpackage

// File: rtl/mult_booth_unit_booth_step.sv
// One radix-2 Booth step: conditional add/subtract of the multiplicand
// followed by an arithmetic right shift of {acc, q, q_m1}.
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   mcand,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_m1_nxt
);

  logic [WIDTH:0] sum;

  always_comb begin
    case ({q[0], q_m1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    acc_nxt  = {sum[WIDTH], sum[WIDTH:1]};
    q_nxt    = {sum[0], q[WIDTH-1:1]};
    q_m1_nxt = q[0];
  end

endmodule

// File: rtl/mult_booth_unit.sv
// Iterative signed multiplier for MULT: one Booth step per cycle, WIDTH steps,
// result published to Hi/Lo together with a one-cycle MultDone pulse.
module mult_booth_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             MultStart,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             MultBusy,
  output logic             MultDone
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  mult_state_e      state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_m1_q, q_m1_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] q_step;
  logic             q_m1_step;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .q        (q_q),
    .q_m1     (q_m1_q),
    .mcand    (mcand_q),
    .acc_nxt  (acc_step),
    .q_nxt    (q_step),
    .q_m1_nxt (q_m1_step)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    q_d     = q_q;
    q_m1_d  = q_m1_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MULT_IDLE: begin
        if (MultStart) begin
          mcand_d = {A[WIDTH-1], A};
          acc_d   = '0;
          q_d     = B;
          q_m1_d  = 1'b0;
          count_d = '0;
          state_d = MULT_RUN;
        end
      end
      MULT_RUN: begin
        acc_d   = acc_step;
        q_d     = q_step;
        q_m1_d  = q_m1_step;
        count_d = count_q + CW'(1);
        // Low WIDTH bits of acc plus q hold the full 2*WIDTH product after the last step
        if (count_q == LAST_STEP) begin
          hi_d    = acc_step[WIDTH-1:0];
          lo_d    = q_step;
          state_d = MULT_DONE;
        end
      end
      MULT_DONE: state_d = MULT_IDLE;
      default:   state_d = MULT_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= MULT_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      q_q     <= '0;
      q_m1_q  <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      q_q     <= q_d;
      q_m1_q  <= q_m1_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Hi       = hi_q;
  assign Lo       = lo_q;
  assign MultBusy = (state_q != MULT_IDLE);
  assign MultDone = (state_q == MULT_DONE);

endmodule

// File: tb/tb_mult_booth_unit.sv
// Self-checking bench for mult_booth_unit: cycle-level reference model plus
// directed vectors with hand-computed products.
module tb_mult_booth_unit;

  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         MultStart;
  logic [W-1:0] A, B;
  logic [W-1:0] Hi, Lo;
  logic         MultBusy, MultDone;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  // Reference model: phase counts cycles since an accepted start (0 = idle)
  int          m_phase = 0;
  logic [63:0] m_prod  = '0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;

  mult_booth_unit #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .MultStart (MultStart),
    .A         (A),
    .B         (B),
    .Hi        (Hi),
    .Lo        (Lo),
    .MultBusy  (MultBusy),
    .MultDone  (MultDone)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clock) begin
    if (Reset) begin
      m_phase = 0;
      exp_hi  = '0;
      exp_lo  = '0;
    end else if (m_phase == 0) begin
      if (MultStart === 1'b1) begin
        m_prod  = 64'(longint'($signed(A)) * longint'($signed(B)));
        m_phase = 1;
      end
    end else begin
      m_phase++;
      if (m_phase == W + 1) begin
        exp_hi = m_prod[63:32];
        exp_lo = m_prod[31:0];
      end else if (m_phase == W + 2) begin
        m_phase = 0;
      end
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("model_hi",   64'(Hi), 64'(exp_hi));
      chk("model_lo",   64'(Lo), 64'(exp_lo));
      chk("model_busy", 64'(MultBusy), 64'(m_phase != 0));
      chk("model_done", 64'(MultDone), 64'(m_phase == W + 1));
      if (MultDone === 1'b1) done_cnt++;
    end
  end

  // Start one multiply and wait for MultDone; lat = edges from start edge to done cycle
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge Clock);
    A = a; B = b; MultStart = 1'b1;
    @(negedge Clock);
    MultStart = 1'b0;
    A = $urandom; B = $urandom;
    lat = 1;
    while (MultDone !== 1'b1 && lat < 100) begin
      @(negedge Clock);
      lat++;
    end
    if (lat >= 100) begin
      n_assert++;
      n_fail++;
      $display("FAIL done_timeout: no MultDone within 100 cycles");
    end
  endtask

  task automatic op_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] hi_e, input logic [W-1:0] lo_e);
    int lat;
    run_op(a, b, lat);
    chk({name, "_lat"}, 64'(lat), 64'(W + 1));
    chk({name, "_hi"}, 64'(Hi), 64'(hi_e));
    chk({name, "_lo"}, 64'(Lo), 64'(lo_e));
  endtask

  initial begin
    int lat, base, first_seen;
    logic [63:0] ref_p;
    Reset = 1'b1; MultStart = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge Clock);
    chk("rst_hi", 64'(Hi), 64'h0);
    chk("rst_lo", 64'(Lo), 64'h0);
    chk("rst_busy", 64'(MultBusy), 64'h0);
    chk("rst_done", 64'(MultDone), 64'h0);
    Reset = 1'b0;
    chk_en = 1'b1;

    op_check("t1_3x5", 32'd3, 32'd5, 32'h0, 32'h0000000F);
    op_check("t2_m1x1", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    op_check("t2_m7xm6", 32'hFFFFFFF9, 32'hFFFFFFFA, 32'h0, 32'h0000002A);
    op_check("t3_minxmin", 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    op_check("t3_maxxmax", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001);
    op_check("t3_minx1", 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000);
    repeat (2) @(negedge Clock);

    // Start held for 40 cycles while A/B change
    base = done_cnt;
    first_seen = 0;
    for (int i = 0; i < 40; i++) begin
      MultStart = 1'b1;
      A = (i == 0) ? 32'd5 : 32'(i + 100);
      B = (i == 0) ? 32'd7 : 32'(i + 3);
      @(negedge Clock);
      if (MultDone === 1'b1 && first_seen == 0) begin
        first_seen = 1;
        chk("t4_first_lat", 64'(i + 1), 64'(W + 1));
        chk("t4_first_hi", 64'(Hi), 64'h0);
        chk("t4_first_lo", 64'(Lo), 64'd35);
      end
    end
    MultStart = 1'b0;
    repeat (40) @(negedge Clock);
    chk("t4_seen_first", 64'(first_seen), 64'd1);
    chk("t4_done_pulses", 64'(done_cnt - base), 64'd2);

    // Abort by reset during RUN
    op_check("t5_prior", 32'h1234, 32'd1, 32'h0, 32'h00001234);
    @(negedge Clock);
    A = 32'd3; B = 32'd4; MultStart = 1'b1;
    @(negedge Clock);
    MultStart = 1'b0;
    repeat (9) @(negedge Clock);
    chk("t5_busy_before", 64'(MultBusy), 64'd1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("t5_hi", 64'(Hi), 64'h0);
    chk("t5_lo", 64'(Lo), 64'h0);
    chk("t5_busy", 64'(MultBusy), 64'h0);
    chk("t5_done", 64'(MultDone), 64'h0);
    base = done_cnt;
    repeat (40) @(negedge Clock);
    chk("t5_no_done", 64'(done_cnt - base), 64'd0);
    op_check("t5_2x3", 32'd2, 32'd3, 32'h0, 32'd6);

    // Random signed operands against direct 64-bit product
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 0) rb = 32'h80000000;
      ref_p = 64'(longint'($signed(ra)) * longint'($signed(rb)));
      run_op(ra, rb, lat);
      chk("rnd_lat", 64'(lat), 64'(W + 1));
      chk("rnd_prod", {Hi, Lo}, ref_p);
    end

    repeat (3) @(negedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
